car_l2_bank_xbar: RTL and testbench



---
 rtl/car_l2_pkg.sv | 14 +
 rtl/car_l2_bank_decode.sv | 63 ++++++
 rtl/car_l2_bank_xbar.sv | 216 +++++++++++++++++++++
 tb/tb_car_l2_bank_xbar.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/car_l2_pkg.sv
// car_l2_pkg: shared constants and types for the L2 bank crossbar.
// Holds the two L2 alias bases and the address map classification.
package car_l2_pkg;

   localparam logic [47:0] L2InterlBase = 48'h0000_7800_0000;
   localparam logic [47:0] L2ContigBase = 48'h0000_7810_0000;

   typedef enum logic [1:0] {
      INTERLEAVE,
      CONTIGUOUS,
      DECERR
   } l2_map_e;

endpackage

// File: rtl/car_l2_bank_decode.sv
// car_l2_bank_decode: byte address -> map type, bank and row.
// Purely combinational; one instance per requesting port.
module car_l2_bank_decode
   import car_l2_pkg::*;
#(
   parameter int unsigned AddrWidth = 48,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned NumBank   = 4,
   parameter int unsigned BankWords = 2**14,
   parameter int unsigned BankBits  = $clog2(NumBank),
   parameter int unsigned RowWidth  = $clog2(BankWords),
   parameter int unsigned MemSize   = NumBank*BankWords*DataWidth/8,
   parameter logic [AddrWidth-1:0] InterlBase = AddrWidth'(L2InterlBase),
   parameter logic [AddrWidth-1:0] ContigBase = AddrWidth'(L2ContigBase)
) (
   input  logic [AddrWidth-1:0] addr_i,
   output l2_map_e              map_o,
   output logic [BankBits-1:0]  bank_o,
   output logic [RowWidth-1:0]  row_o
);

   localparam int unsigned ByteBits = $clog2(DataWidth/8);
   localparam int unsigned WordBits = BankBits + RowWidth;
   localparam logic [AddrWidth-1:0] Size = AddrWidth'(MemSize);

   logic [AddrWidth-1:0] off_il;
   logic [AddrWidth-1:0] off_ct;
   logic                 hit_il;
   logic                 hit_ct;
   logic [WordBits-1:0]  w_il;
   logic [WordBits-1:0]  w_ct;
   logic                 unused_off;

   // Offsets wrap below the base, so the lower-bound test is explicit.
   assign off_il = addr_i - InterlBase;
   assign off_ct = addr_i - ContigBase;
   assign hit_il = (addr_i >= InterlBase) && (off_il < Size);
   assign hit_ct = (addr_i >= ContigBase) && (off_ct < Size);
   assign w_il   = off_il[ByteBits +: WordBits];
   assign w_ct   = off_ct[ByteBits +: WordBits];

   assign unused_off = ^{off_il[ByteBits-1:0],
                         off_il[AddrWidth-1:ByteBits+WordBits],
                         off_ct[ByteBits-1:0],
                         off_ct[AddrWidth-1:ByteBits+WordBits]};

   // Interleaved: low word bits pick the bank; contiguous: high bits do.
   always_comb begin
      map_o  = DECERR;
      bank_o = '0;
      row_o  = '0;
      if (hit_il) begin
         map_o  = INTERLEAVE;
         bank_o = w_il[BankBits-1:0];
         row_o  = w_il[BankBits +: RowWidth];
      end else if (hit_ct) begin
         map_o  = CONTIGUOUS;
         bank_o = w_ct[RowWidth +: BankBits];
         row_o  = w_ct[RowWidth-1:0];
      end
   end

endmodule

// File: rtl/car_l2_bank_xbar.sv
// car_l2_bank_xbar: multi-port, multi-bank L2 SRAM crossbar front-end.
// Optional ECC event counter: define CAR_L2_ECC_CNT_EN to build it.
module car_l2_bank_xbar
   import car_l2_pkg::*;
#(
   parameter int unsigned NumPort   = 2,
   parameter int unsigned NumBank   = 4,
   parameter int unsigned AddrWidth = 48,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned BankWords = 2**14,
   parameter logic [AddrWidth-1:0] InterlBase = AddrWidth'(L2InterlBase),
   parameter logic [AddrWidth-1:0] ContigBase = AddrWidth'(L2ContigBase),
   localparam int unsigned RowWidth = $clog2(BankWords),
   localparam int unsigned StrbW    = DataWidth/8
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NumPort-1:0]                  req_i,
   output logic [NumPort-1:0]                  gnt_o,
   input  logic [NumPort-1:0][AddrWidth-1:0]   addr_i,
   input  logic [NumPort-1:0]                  we_i,
   input  logic [NumPort-1:0][DataWidth-1:0]   wdata_i,
   input  logic [NumPort-1:0][StrbW-1:0]       be_i,
   output logic [NumPort-1:0]                  rvalid_o,
   output logic [NumPort-1:0][DataWidth-1:0]   rdata_o,
   output logic [NumPort-1:0]                  err_o,
   output logic [NumBank-1:0]                  bank_req_o,
   output logic [NumBank-1:0]                  bank_we_o,
   output logic [NumBank-1:0][RowWidth-1:0]    bank_addr_o,
   output logic [NumBank-1:0][DataWidth-1:0]   bank_wdata_o,
   output logic [NumBank-1:0][StrbW-1:0]       bank_be_o,
   input  logic [NumBank-1:0][DataWidth-1:0]   bank_rdata_i,
   input  logic [NumBank-1:0]                  bank_ecc_err_i,
   input  logic                                ecc_clr_i,
   output logic                                ecc_error_o,
   output logic [15:0]                         ecc_cnt_o
);

   localparam int unsigned BankBits  = $clog2(NumBank);
   localparam int unsigned PortBits  = (NumPort > 1) ? $clog2(NumPort) : 1;
   localparam int unsigned L2MemSize = NumBank*BankWords*DataWidth/8;

   l2_map_e                           map   [NumPort];
   logic [NumPort-1:0][BankBits-1:0]  bank;
   logic [NumPort-1:0][RowWidth-1:0]  row;
   logic [NumPort-1:0]                req_act;
   logic [NumPort-1:0]                decerr;
   logic [NumBank-1:0][NumPort-1:0]   hit;
   logic [NumBank-1:0]                win_vld;
   logic [NumBank-1:0][PortBits-1:0]  win_idx;
   logic [NumBank-1:0][PortBits-1:0]  rr_d;
   logic [NumBank-1:0][PortBits-1:0]  rr_q;
   logic [NumPort-1:0]                rsp_valid_q;
   logic [NumPort-1:0][BankBits-1:0]  rsp_bank_q;
   logic [NumPort-1:0]                rsp_err_q;
   logic [NumPort-1:0]                rsp_we_q;
   logic                              ecc_hit;

   for (genvar p = 0; p < NumPort; p++) begin : g_dec
      car_l2_bank_decode #(
         .AddrWidth  (AddrWidth),
         .DataWidth  (DataWidth),
         .NumBank    (NumBank),
         .BankWords  (BankWords),
         .BankBits   (BankBits),
         .RowWidth   (RowWidth),
         .MemSize    (L2MemSize),
         .InterlBase (InterlBase),
         .ContigBase (ContigBase)
      ) u_dec (
         .addr_i (addr_i[p]),
         .map_o  (map[p]),
         .bank_o (bank[p]),
         .row_o  (row[p])
      );
   end

   // Requests are masked while in reset so every output idles at zero.
   assign req_act = req_i & {NumPort{~rst_i}};

   // Split requests into decode errors and per-bank candidates.
   always_comb begin
      decerr = '0;
      hit    = '0;
      for (int p = 0; p < NumPort; p++) begin
         decerr[p] = req_act[p] && (map[p] == DECERR);
         for (int b = 0; b < NumBank; b++) begin
            hit[b][p] = req_act[p] && (map[p] != DECERR)
                        && (bank[p] == BankBits'(b));
         end
      end
   end

   // Per-bank round robin: first requester at or after rr_q wins.
   always_comb begin
      int idx;
      idx     = 0;
      win_vld = '0;
      win_idx = '0;
      rr_d    = rr_q;
      for (int b = 0; b < NumBank; b++) begin
         for (int k = 0; k < NumPort; k++) begin
            idx = (int'(rr_q[b]) + k) % NumPort;
            if (!win_vld[b] && hit[b][PortBits'(idx)]) begin
               win_vld[b] = 1'b1;
               win_idx[b] = PortBits'(idx);
            end
         end
         if (win_vld[b]) begin
            rr_d[b] = PortBits'((int'(win_idx[b]) + 1) % NumPort);
         end
      end
   end

   // Decode errors are granted at once; bank traffic needs the winner slot.
   always_comb begin
      gnt_o = decerr;
      for (int p = 0; p < NumPort; p++) begin
         if (hit[bank[p]][p] && win_vld[bank[p]]
             && (win_idx[bank[p]] == PortBits'(p))) begin
            gnt_o[p] = 1'b1;
         end
      end
   end

   // Steer the winning port onto its bank; idle banks drive zeros.
   always_comb begin
      bank_req_o   = win_vld;
      bank_we_o    = '0;
      bank_addr_o  = '0;
      bank_wdata_o = '0;
      bank_be_o    = '0;
      for (int b = 0; b < NumBank; b++) begin
         if (win_vld[b]) begin
            bank_we_o[b]    = we_i[win_idx[b]];
            bank_addr_o[b]  = row[win_idx[b]];
            bank_wdata_o[b] = wdata_i[win_idx[b]];
            bank_be_o[b]    = be_i[win_idx[b]];
         end
      end
   end

   // Round-robin pointers advance only on a grant.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end

   // Remember each grant so the response lands exactly one cycle later.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_valid_q <= '0;
         rsp_bank_q  <= '0;
         rsp_err_q   <= '0;
         rsp_we_q    <= '0;
      end else begin
         rsp_valid_q <= gnt_o;
         rsp_bank_q  <= bank;
         rsp_err_q   <= decerr;
         rsp_we_q    <= we_i;
      end
   end

   // Return path: bank data for good responses, zero otherwise.
   always_comb begin
      rvalid_o = rsp_valid_q;
      err_o    = rsp_valid_q & rsp_err_q;
      rdata_o  = '0;
      ecc_hit  = 1'b0;
      for (int p = 0; p < NumPort; p++) begin
         if (rsp_valid_q[p] && !rsp_err_q[p]) begin
            rdata_o[p] = bank_rdata_i[rsp_bank_q[p]];
            if (!rsp_we_q[p] && bank_ecc_err_i[rsp_bank_q[p]]) begin
               ecc_hit = 1'b1;
            end
         end
      end
   end

   assign ecc_error_o = ecc_hit;

`ifdef CAR_L2_ECC_CNT_EN
   logic [15:0] ecc_cnt_d;
   logic [15:0] ecc_cnt_q;

   // Saturating event count; a clear beats a coincident error.
   always_comb begin
      ecc_cnt_d = ecc_cnt_q;
      if (ecc_clr_i) begin
         ecc_cnt_d = '0;
      end else if (ecc_hit && (ecc_cnt_q != 16'hFFFF)) begin
         ecc_cnt_d = ecc_cnt_q + 16'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ecc_cnt_q <= '0;
      end else begin
         ecc_cnt_q <= ecc_cnt_d;
      end
   end

   assign ecc_cnt_o = ecc_cnt_q;
`else
   logic unused_clr;

   assign unused_clr = ecc_clr_i;
   assign ecc_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_car_l2_bank_xbar.sv
// tb_car_l2_bank_xbar: directed self-checking bench for car_l2_bank_xbar.
// Expected ECC counts follow CAR_L2_ECC_CNT_EN when it is defined.
module tb_car_l2_bank_xbar;
   import car_l2_pkg::*;

   localparam int NP = 2;
   localparam int NB = 4;
   localparam int AW = 48;
   localparam int DW = 64;
   localparam int BW = 2**14;
   localparam int RW = 14;
   localparam logic [AW-1:0] IB = L2InterlBase;
   localparam logic [AW-1:0] CB = L2ContigBase;
   localparam logic [AW-1:0] MS = 48'h8_0000;
`ifdef CAR_L2_ECC_CNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NP-1:0]             req;
   logic [NP-1:0]             gnt_o;
   logic [NP-1:0][AW-1:0]     addr;
   logic [NP-1:0]             we;
   logic [NP-1:0][DW-1:0]     wdata;
   logic [NP-1:0][DW/8-1:0]   be;
   logic [NP-1:0]             rvalid_o;
   logic [NP-1:0][DW-1:0]     rdata_o;
   logic [NP-1:0]             err_o;
   logic [NB-1:0]             bank_req_o;
   logic [NB-1:0]             bank_we_o;
   logic [NB-1:0][RW-1:0]     bank_addr_o;
   logic [NB-1:0][DW-1:0]     bank_wdata_o;
   logic [NB-1:0][DW/8-1:0]   bank_be_o;
   logic [NB-1:0][DW-1:0]     rd_q;
   logic [NB-1:0]             ecc_in;
   logic                      ecc_clr;
   logic                      ecc_error_o;
   logic [15:0]               ecc_cnt_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   car_l2_bank_xbar dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_i          (req),
      .gnt_o          (gnt_o),
      .addr_i         (addr),
      .we_i           (we),
      .wdata_i        (wdata),
      .be_i           (be),
      .rvalid_o       (rvalid_o),
      .rdata_o        (rdata_o),
      .err_o          (err_o),
      .bank_req_o     (bank_req_o),
      .bank_we_o      (bank_we_o),
      .bank_addr_o    (bank_addr_o),
      .bank_wdata_o   (bank_wdata_o),
      .bank_be_o      (bank_be_o),
      .bank_rdata_i   (rd_q),
      .bank_ecc_err_i (ecc_in),
      .ecc_clr_i      (ecc_clr),
      .ecc_error_o    (ecc_error_o),
      .ecc_cnt_o      (ecc_cnt_o)
   );

   function automatic logic [DW-1:0] pat(int b, int r);
      return {16'hC0DE, 16'(b), 32'(r)};
   endfunction

   // Simple SRAM model: unwritten rows read back a per-location pattern.
   logic [DW-1:0]       mem [NB][256];
   logic [NB-1:0][255:0] wv;
   always @(posedge clk or posedge rst) begin : sram_m
      logic [7:0]    r;
      logic [DW-1:0] old;
      logic [DW-1:0] t;
      if (rst) begin
         wv   <= '0;
         rd_q <= '0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (bank_req_o[b]) begin
               r   = bank_addr_o[b][7:0];
               old = wv[b][r] ? mem[b][r] : pat(b, int'(r));
               if (bank_we_o[b]) begin
                  t = old;
                  for (int j = 0; j < DW/8; j++)
                     if (bank_be_o[b][j]) t[j*8 +: 8] = bank_wdata_o[b][j*8 +: 8];
                  mem[b][r] <= t;
                  wv[b][r]  <= 1'b1;
               end else begin
                  rd_q[b] <= old;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req     = '0;
      we      = '0;
      addr    = '0;
      wdata   = '0;
      be      = '0;
      ecc_in  = '0;
      ecc_clr = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      #2;
      n_cmp++; if (rvalid_o !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid got %b want 00", rvalid_o); end
      n_cmp++; if (err_o !== 2'b00) begin n_bad++; $display("FAIL reset_err got %b want 00", err_o); end
      n_cmp++; if (rdata_o !== '0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
      n_cmp++; if (ecc_error_o !== 1'b0) begin n_bad++; $display("FAIL reset_ecc got %b want 0", ecc_error_o); end
      n_cmp++; if (ecc_cnt_o !== 16'h0) begin n_bad++; $display("FAIL reset_cnt got %h want 0", ecc_cnt_o); end
      req = 2'b01;
      addr[0] = IB;
      #1;
      n_cmp++; if (gnt_o !== 2'b00) begin n_bad++; $display("FAIL reset_gnt got %b want 00", gnt_o); end
      n_cmp++; if (bank_req_o !== 4'b0000) begin n_bad++; $display("FAIL reset_bank_req got %b want 0000", bank_req_o); end
      idle();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_interleave();
      for (int i = 0; i < 4; i++) begin
         req = 2'b01;
         addr[0] = IB + AW'(8*i);
         #1;
         n_cmp++; if (gnt_o !== 2'b01) begin n_bad++; $display("FAIL il_gnt%0d got %b want 01", i, gnt_o); end
         n_cmp++; if (bank_req_o !== 4'(1 << i)) begin n_bad++; $display("FAIL il_bank%0d got %b want %b", i, bank_req_o, 4'(1 << i)); end
         n_cmp++; if (bank_addr_o[i] !== '0) begin n_bad++; $display("FAIL il_row%0d got %h want 0", i, bank_addr_o[i]); end
         if (i > 0) begin
            n_cmp++; if (rvalid_o !== 2'b01 || rdata_o[0] !== pat(i-1, 0)) begin n_bad++; $display("FAIL il_rsp%0d got %b/%h want 01/%h", i-1, rvalid_o, rdata_o[0], pat(i-1, 0)); end
         end
         tick();
      end
      idle();
      #1;
      n_cmp++; if (rvalid_o !== 2'b01 || err_o !== 2'b00 || rdata_o[0] !== pat(3, 0)) begin n_bad++; $display("FAIL il_rsp3 got %b/%b/%h want 01/00/%h", rvalid_o, err_o, rdata_o[0], pat(3, 0)); end
      tick();
      n_cmp++; if (rvalid_o !== 2'b00) begin n_bad++; $display("FAIL il_idle got %b want 00", rvalid_o); end
   endtask

   task automatic test_contig();
      req = 2'b10;
      we = 2'b10;
      addr[1] = CB + AW'(BW*8);
      wdata[1] = 64'h1122_3344_5566_7788;
      be[1] = 8'h0F;
      #1;
      n_cmp++; if (gnt_o !== 2'b10) begin n_bad++; $display("FAIL ct_gnt got %b want 10", gnt_o); end
      n_cmp++; if (bank_req_o !== 4'b0010 || bank_we_o !== 4'b0010) begin n_bad++; $display("FAIL ct_bank got %b/%b want 0010/0010", bank_req_o, bank_we_o); end
      n_cmp++; if (bank_addr_o[1] !== '0) begin n_bad++; $display("FAIL ct_row got %h want 0", bank_addr_o[1]); end
      n_cmp++; if (bank_be_o[1] !== 8'h0F) begin n_bad++; $display("FAIL ct_be got %h want 0f", bank_be_o[1]); end
      n_cmp++; if (bank_wdata_o[1] !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL ct_wdata got %h want 1122334455667788", bank_wdata_o[1]); end
      tick();
      we = 2'b00;
      #1;
      n_cmp++; if (rvalid_o !== 2'b10 || err_o !== 2'b00) begin n_bad++; $display("FAIL ct_wrsp got %b/%b want 10/00", rvalid_o, err_o); end
      tick();
      idle();
      req = 2'b01;
      addr[0] = CB + 48'h18;
      #1;
      n_cmp++; if (rvalid_o !== 2'b10 || rdata_o[1] !== 64'hC0DE_0001_5566_7788) begin n_bad++; $display("FAIL ct_rdata got %b/%h want 10/c0de000155667788", rvalid_o, rdata_o[1]); end
      n_cmp++; if (bank_req_o !== 4'b0001 || bank_addr_o[0] !== 14'd3) begin n_bad++; $display("FAIL ct_row3 got %b/%h want 0001/3", bank_req_o, bank_addr_o[0]); end
      tick();
      idle();
      #1;
      n_cmp++; if (rdata_o[0] !== pat(0, 3)) begin n_bad++; $display("FAIL ct_rd3 got %h want %h", rdata_o[0], pat(0, 3)); end
      tick();
   endtask

   task automatic test_conflict();
      logic [1:0] exp_g [4];
      int c0;
      int c1;
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      c0 = 0;
      c1 = 0;
      do_reset();
      req = 2'b11;
      addr[0] = IB + 48'h10;
      addr[1] = IB + 48'h30;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_cmp++; if (gnt_o !== exp_g[c]) begin n_bad++; $display("FAIL cf_gnt%0d got %b want %b", c, gnt_o, exp_g[c]); end
         n_cmp++; if (bank_req_o !== 4'b0100 || bank_addr_o[2] !== 14'(c % 2)) begin n_bad++; $display("FAIL cf_bank%0d got %b/%h want 0100/%0d", c, bank_req_o, bank_addr_o[2], c % 2); end
         c0 += int'(rvalid_o[0]);
         c1 += int'(rvalid_o[1]);
         tick();
      end
      idle();
      for (int c = 0; c < 2; c++) begin
         c0 += int'(rvalid_o[0]);
         c1 += int'(rvalid_o[1]);
         tick();
      end
      n_cmp++; if (c0 !== 2 || c1 !== 2) begin n_bad++; $display("FAIL cf_count got %0d/%0d want 2/2", c0, c1); end
   endtask

   task automatic test_decerr();
      req = 2'b01;
      addr[0] = IB + MS;
      #1;
      n_cmp++; if (gnt_o !== 2'b01) begin n_bad++; $display("FAIL de_gnt got %b want 01", gnt_o); end
      n_cmp++; if (bank_req_o !== 4'b0000) begin n_bad++; $display("FAIL de_bank got %b want 0000", bank_req_o); end
      tick();
      idle();
      req = 2'b10;
      addr[1] = CB - 48'h8;
      #1;
      n_cmp++; if (rvalid_o !== 2'b01 || err_o !== 2'b01 || rdata_o[0] !== '0) begin n_bad++; $display("FAIL de_rsp got %b/%b/%h want 01/01/0", rvalid_o, err_o, rdata_o[0]); end
      n_cmp++; if (gnt_o !== 2'b10 || bank_req_o !== 4'b0000) begin n_bad++; $display("FAIL de_low got %b/%b want 10/0000", gnt_o, bank_req_o); end
      tick();
      idle();
      #1;
      n_cmp++; if (rvalid_o !== 2'b10 || err_o !== 2'b10) begin n_bad++; $display("FAIL de_rsp2 got %b/%b want 10/10", rvalid_o, err_o); end
      tick();
   endtask

   task automatic test_ecc();
      do_reset();
      req = 2'b01;
      addr[0] = IB;
      tick();
      idle();
      ecc_in = 4'b0001;
      #1;
      n_cmp++; if (ecc_error_o !== 1'b1) begin n_bad++; $display("FAIL ecc_pulse got %b want 1", ecc_error_o); end
      n_cmp++; if (ecc_cnt_o !== 16'd0) begin n_bad++; $display("FAIL ecc_cnt0 got %h want 0", ecc_cnt_o); end
      tick();
      ecc_in = '0;
      #1;
      n_cmp++; if (ecc_error_o !== 1'b0 || ecc_cnt_o !== (CntEn ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL ecc_cnt1 got %b/%h want 0/%h", ecc_error_o, ecc_cnt_o, CntEn ? 16'd1 : 16'd0); end
      req = 2'b01;
      we = 2'b01;
      addr[0] = IB;
      be[0] = 8'h00;
      tick();
      idle();
      ecc_in = 4'b0001;
      #1;
      n_cmp++; if (ecc_error_o !== 1'b0) begin n_bad++; $display("FAIL ecc_write got %b want 0", ecc_error_o); end
      ecc_in = '0;
      req = 2'b11;
      addr[0] = IB;
      addr[1] = IB + 48'h8;
      tick();
      idle();
      ecc_in = 4'b0011;
      #1;
      n_cmp++; if (ecc_error_o !== 1'b1) begin n_bad++; $display("FAIL ecc_dual got %b want 1", ecc_error_o); end
      tick();
      ecc_in = '0;
      #1;
      n_cmp++; if (ecc_cnt_o !== (CntEn ? 16'd2 : 16'd0)) begin n_bad++; $display("FAIL ecc_cnt2 got %h want %h", ecc_cnt_o, CntEn ? 16'd2 : 16'd0); end
`ifdef CAR_L2_ECC_CNT_EN
      req = 2'b01;
      addr[0] = IB;
      ecc_in = 4'b0001;
      for (int i = 0; i < 65533; i++) tick();
      req = 2'b00;
      tick();
      n_cmp++; if (ecc_cnt_o !== 16'hFFFF) begin n_bad++; $display("FAIL ecc_full got %h want ffff", ecc_cnt_o); end
      req = 2'b01;
      tick();
      req = 2'b00;
      tick();
      n_cmp++; if (ecc_cnt_o !== 16'hFFFF) begin n_bad++; $display("FAIL ecc_sat got %h want ffff", ecc_cnt_o); end
      ecc_in = '0;
`endif
      req = 2'b01;
      addr[0] = IB;
      tick();
      idle();
      ecc_in = 4'b0001;
      ecc_clr = 1'b1;
      #1;
      n_cmp++; if (ecc_error_o !== 1'b1) begin n_bad++; $display("FAIL ecc_clr_pulse got %b want 1", ecc_error_o); end
      tick();
      idle();
      n_cmp++; if (ecc_cnt_o !== 16'd0) begin n_bad++; $display("FAIL ecc_clr got %h want 0", ecc_cnt_o); end
   endtask

   task automatic test_reset_mid();
      req = 2'b01;
      addr[0] = IB + 48'h8;
      #1;
      n_cmp++; if (gnt_o !== 2'b01) begin n_bad++; $display("FAIL rm_gnt got %b want 01", gnt_o); end
      tick();
      idle();
      rst = 1'b1;
      ecc_in = 4'b1111;
      req = 2'b10;
      addr[1] = IB;
      #1;
      n_cmp++; if (rvalid_o !== 2'b00 || rdata_o !== '0 || err_o !== 2'b00) begin n_bad++; $display("FAIL rm_rsp got %b/%h/%b want 00/0/00", rvalid_o, rdata_o, err_o); end
      n_cmp++; if (gnt_o !== 2'b00 || bank_req_o !== 4'b0000) begin n_bad++; $display("FAIL rm_gnt_rst got %b/%b want 00/0000", gnt_o, bank_req_o); end
      n_cmp++; if (ecc_error_o !== 1'b0 || ecc_cnt_o !== 16'd0) begin n_bad++; $display("FAIL rm_ecc got %b/%h want 0/0", ecc_error_o, ecc_cnt_o); end
      tick();
      idle();
      rst = 1'b0;
      #1;
      n_cmp++; if (rvalid_o !== 2'b00) begin n_bad++; $display("FAIL rm_late got %b want 00", rvalid_o); end
      tick();
      n_cmp++; if (rvalid_o !== 2'b00) begin n_bad++; $display("FAIL rm_late2 got %b want 00", rvalid_o); end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      tick();
      test_reset();
      test_interleave();
      test_contig();
      test_conflict();
      test_decerr();
      test_ecc();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
